// File: rtl/vram_pkg.sv
// Shared types and timing defaults for the VRAM controller: FSM state encoding
// and small state-classification helpers used to derive the SRAM pin levels.
package vram_pkg;

  localparam int ADDR_W_DEF       = 17;
  localparam int DATA_W           = 8;
  localparam int READ_CYCLES_DEF  = 2;
  localparam int WRITE_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    VID_READ = 3'd1,
    MCU_READ = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5,
    TURN     = 3'd6
  } vram_state_t;

  function automatic logic is_read_state(input vram_state_t s);
    return (s == VID_READ) || (s == MCU_READ);
  endfunction

  function automatic logic is_drive_state(input vram_state_t s);
    return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/vram_controller_if.sv
// MCU write/read-back and video scan-out signals between the requesters and the
// VRAM controller; master = requester side, slave = controller side.
interface vram_controller_if #(
  parameter int ADDR_W = 17
);
  logic              memoryWriteRequest;
  logic [ADDR_W-1:0] memoryWriteAddress;
  logic [7:0]        memoryWriteData;
  logic              memoryWriteComplete;
  logic [ADDR_W-1:0] memoryReadAddress;
  logic [7:0]        memoryReadData;
  logic              videoReadRequest;
  logic [ADDR_W-1:0] videoReadAddress;
  logic [7:0]        videoReadData;
  logic              videoReadValid;

  modport master (
    output memoryWriteRequest, memoryWriteAddress, memoryWriteData,
    output memoryReadAddress, videoReadRequest, videoReadAddress,
    input  memoryWriteComplete, memoryReadData, videoReadData, videoReadValid
  );

  modport slave (
    input  memoryWriteRequest, memoryWriteAddress, memoryWriteData,
    input  memoryReadAddress, videoReadRequest, videoReadAddress,
    output memoryWriteComplete, memoryReadData, videoReadData, videoReadValid
  );
endinterface

// File: rtl/vram_controller.sv
// Async-SRAM responder: arbitrates video scan-out reads, MCU writes and MCU
// read-back refreshes onto a 128Kx8 SRAM; every pin and result is registered.
module vram_controller
  import vram_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int READ_CYCLES  = READ_CYCLES_DEF,
  parameter int WRITE_CYCLES = WRITE_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              resetN,
  vram_controller_if.slave  bus,
  output logic [ADDR_W-1:0] sramAddress,
  inout  wire  [7:0]        sramData,
  output logic              sramChipEnableN,
  output logic              sramOutputEnableN,
  output logic              sramWriteEnableN
);

  localparam int CNT_MAX = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_CYCLES - 1);

  vram_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              drive_q, drive_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              complete_q, complete_d;
  logic              vid_valid_q, vid_valid_d;
  logic [7:0]        vid_data_q, vid_data_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] capt_addr_q, capt_addr_d;
  logic [ADDR_W-1:0] trk_addr_q, trk_addr_d;
  logic              trk_valid_q, trk_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;
  logic              refresh_s;
  logic              snoop_hit_s;

  assign refresh_s   = !trk_valid_q || (bus.memoryReadAddress != trk_addr_q);
  assign snoop_hit_s = trk_valid_q && (bus.memoryWriteAddress == trk_addr_q);

  // Next-state, arbitration and capture logic; pin levels follow the next state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    complete_d  = 1'b0;
    vid_valid_d = 1'b0;
    vid_data_d  = vid_data_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    capt_addr_d = capt_addr_q;
    trk_addr_d  = trk_addr_q;
    trk_valid_d = trk_valid_q;
    rd_data_d   = rd_data_q;

    case (state_q)
      IDLE: begin
        // A strobe arriving this cycle outranks a write, so hold off until it is latched
        if (pend_q) begin
          state_d = VID_READ;
          cnt_d   = {CNT_W{1'b0}};
          addr_d  = pend_addr_q;
          pend_d  = 1'b0;
        end else if (bus.videoReadRequest) begin
          state_d = IDLE;
        end else if (bus.memoryWriteRequest && !complete_q) begin
          state_d = WR_SETUP;
          addr_d  = bus.memoryWriteAddress;
          dout_d  = bus.memoryWriteData;
        end else if (refresh_s) begin
          state_d     = MCU_READ;
          cnt_d       = {CNT_W{1'b0}};
          addr_d      = bus.memoryReadAddress;
          capt_addr_d = bus.memoryReadAddress;
        end else begin
          state_d = IDLE;
        end
      end
      VID_READ: begin
        if (cnt_q == RD_LAST) begin
          state_d     = IDLE;
          vid_data_d  = sramData;
          vid_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MCU_READ: begin
        if (cnt_q == RD_LAST) begin
          state_d     = IDLE;
          rd_data_d   = sramData;
          trk_addr_d  = capt_addr_q;
          trk_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = {CNT_W{1'b0}};
      end
      WR_PULSE: begin
        if (cnt_q == WR_LAST) begin
          state_d    = WR_HOLD;
          complete_d = 1'b1;
          // Keep the read-back byte coherent without spending an SRAM read
          if (snoop_hit_s) begin
            rd_data_d = bus.memoryWriteData;
          end else begin
            rd_data_d = rd_data_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_HOLD: begin
        state_d = TURN;
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.videoReadRequest) begin
      pend_d      = 1'b1;
      pend_addr_d = bus.videoReadAddress;
    end else begin
      pend_d      = pend_d;
      pend_addr_d = pend_addr_d;
    end

    ce_n_d  = (state_d == IDLE);
    oe_n_d  = !is_read_state(state_d);
    we_n_d  = (state_d != WR_PULSE);
    drive_d = is_drive_state(state_d);
  end

  // State and registered outputs, cleared asynchronously by resetN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      addr_q      <= {ADDR_W{1'b0}};
      dout_q      <= 8'h00;
      drive_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      complete_q  <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= 8'h00;
      pend_q      <= 1'b0;
      pend_addr_q <= {ADDR_W{1'b0}};
      capt_addr_q <= {ADDR_W{1'b0}};
      trk_addr_q  <= {ADDR_W{1'b0}};
      trk_valid_q <= 1'b0;
      rd_data_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      drive_q     <= drive_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      complete_q  <= complete_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      capt_addr_q <= capt_addr_d;
      trk_addr_q  <= trk_addr_d;
      trk_valid_q <= trk_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign sramData          = drive_q ? dout_q : 8'bzzzz_zzzz;
  assign sramAddress       = addr_q;
  assign sramChipEnableN   = ce_n_q;
  assign sramOutputEnableN = oe_n_q;
  assign sramWriteEnableN  = we_n_q;

  assign bus.memoryWriteComplete = complete_q;
  assign bus.memoryReadData      = rd_data_q;
  assign bus.videoReadData       = vid_data_q;
  assign bus.videoReadValid      = vid_valid_q;

endmodule

// File: tb/tb_vram_controller.sv
// Bench for vram_controller: behavioural async SRAM, directed scenarios and a
// randomized mix checked against a reference memory image.
module tb_vram_controller;

  logic        clock  = 1'b0;
  logic        resetN = 1'b0;
  wire  [7:0]  sramData;
  logic [16:0] sramAddress;
  logic        ce_n, oe_n, we_n;

  int checks = 0;
  int errors = 0;
  int contention_cnt = 0;

  logic [7:0] sram_mem [0:131071];
  logic       mem_ready = 1'b0;
  logic [7:0] ref_mem [int];

  vram_controller_if #(.ADDR_W(17)) bus ();

  vram_controller #(.ADDR_W(17), .READ_CYCLES(2), .WRITE_CYCLES(2)) dut (
    .clock             (clock),
    .resetN            (resetN),
    .bus               (bus),
    .sramAddress       (sramAddress),
    .sramData          (sramData),
    .sramChipEnableN   (ce_n),
    .sramOutputEnableN (oe_n),
    .sramWriteEnableN  (we_n)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] pattern(input logic [16:0] a);
    return a[7:0] ^ a[15:8] ^ {7'b0, a[16]};
  endfunction

  function automatic logic [7:0] ref_rd(input logic [16:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return pattern(a);
  endfunction

  // Async SRAM: drives while selected and output-enabled, stores while WE low
  assign sramData = (!ce_n && !oe_n && we_n) ? sram_mem[sramAddress] : 8'bzzzz_zzzz;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 131072; i++) sram_mem[i] <= pattern(17'(i));
      mem_ready <= 1'b1;
    end else if (!ce_n && !we_n) begin
      sram_mem[sramAddress] <= sramData;
    end
  end

  // Bus-fight monitor: while OE is low only the SRAM may drive, and WE must be high
  always @(negedge clock) begin
    if (resetN && mem_ready && !oe_n && ((sramData !== sram_mem[sramAddress]) || !we_n))
      contention_cnt <= contention_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    repeat (8) tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (ce_n !== 1'b1) begin errors++; $display("FAIL reset_ce got %b exp 1", ce_n); end
    checks++; if (oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe got %b exp 1", oe_n); end
    checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL reset_we got %b exp 1", we_n); end
    checks++; if (sramAddress !== 17'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", sramAddress); end
    checks++; if (bus.memoryWriteComplete !== 1'b0) begin errors++; $display("FAIL reset_complete got %b exp 0", bus.memoryWriteComplete); end
    checks++; if (bus.videoReadValid !== 1'b0) begin errors++; $display("FAIL reset_vvalid got %b exp 0", bus.videoReadValid); end
    checks++; if (bus.videoReadData !== 8'h00) begin errors++; $display("FAIL reset_vdata got %h exp 00", bus.videoReadData); end
    checks++; if (bus.memoryReadData !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.memoryReadData); end
    resetN = 1'b1;
    settle();
    checks++; if (bus.memoryReadData !== 8'h33) begin errors++; $display("FAIL boot_refresh got %h exp 33", bus.memoryReadData); end
    bus.memoryWriteRequest = 1'b1;
    bus.memoryWriteAddress = 17'h00555;
    bus.memoryWriteData    = 8'hAA;
    tick();
    tick();
    checks++; if (we_n !== 1'b0) begin errors++; $display("FAIL midpulse_we got %b exp 0", we_n); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (we_n !== 1'b1) begin errors++; $display("FAIL abort_we got %b exp 1", we_n); end
    checks++; if (ce_n !== 1'b1) begin errors++; $display("FAIL abort_ce got %b exp 1", ce_n); end
    checks++; if (sramAddress !== 17'h0) begin errors++; $display("FAIL abort_addr got %h exp 0", sramAddress); end
    checks++; if (bus.memoryReadData !== 8'h00) begin errors++; $display("FAIL abort_rdata got %h exp 00", bus.memoryReadData); end
    bus.memoryWriteRequest = 1'b0;
    tick();
    resetN = 1'b1;
    settle();
  endtask

  task automatic test_write();
    int we_low = 0;
    int extra = 0;
    bus.memoryWriteRequest = 1'b1;
    bus.memoryWriteAddress = 17'h1A5A5;
    bus.memoryWriteData    = 8'h3C;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (!we_n) we_low++;
      checks++;
      if (bus.memoryWriteComplete !== (k == 4)) begin
        errors++; $display("FAIL wr_complete_cycle%0d got %b exp %b", k, bus.memoryWriteComplete, (k == 4));
      end
      if (k == 1) begin
        checks++; if (sramData !== 8'h3C) begin errors++; $display("FAIL wr_setup_data got %h exp 3c", sramData); end
        checks++; if (sramAddress !== 17'h1A5A5) begin errors++; $display("FAIL wr_setup_addr got %h exp 1a5a5", sramAddress); end
      end
    end
    tick();
    bus.memoryWriteRequest = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.memoryWriteComplete) extra++;
      if (!we_n) we_low++;
    end
    ref_mem[int'(17'h1A5A5)] = 8'h3C;
    checks++; if (we_low != 2) begin errors++; $display("FAIL wr_we_low_clks got %0d exp 2", we_low); end
    checks++; if (extra != 0) begin errors++; $display("FAIL wr_double_accept got %0d extra pulses exp 0", extra); end
    checks++; if (sram_mem[17'h1A5A5] !== 8'h3C) begin errors++; $display("FAIL wr_sram_content got %h exp 3c", sram_mem[17'h1A5A5]); end
  endtask

  task automatic test_video();
    bus.videoReadRequest = 1'b1;
    bus.videoReadAddress = 17'h00100;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.videoReadRequest = 1'b0;
      checks++;
      if (oe_n !== !(k == 2 || k == 3)) begin errors++; $display("FAIL vid_oe_cycle%0d got %b", k, oe_n); end
      checks++;
      if (bus.videoReadValid !== (k == 4)) begin errors++; $display("FAIL vid_valid_cycle%0d got %b", k, bus.videoReadValid); end
      if (k == 4) begin
        checks++;
        if (bus.videoReadData !== ref_rd(17'h00100)) begin
          errors++; $display("FAIL vid_data got %h exp %h", bus.videoReadData, ref_rd(17'h00100));
        end
      end
    end
    settle();
  endtask

  task automatic test_priority();
    logic [7:0] old_v;
    logic [7:0] vdata = 8'h00;
    int vk = 0, ck = 0, vcnt = 0, ccnt = 0;
    logic drop = 1'b0;
    old_v = ref_rd(17'h00200);
    bus.videoReadRequest   = 1'b1;
    bus.videoReadAddress   = 17'h00200;
    bus.memoryWriteRequest = 1'b1;
    bus.memoryWriteAddress = 17'h00200;
    bus.memoryWriteData    = 8'hC3;
    for (int k = 1; k <= 30; k++) begin
      tick();
      bus.videoReadRequest = 1'b0;
      if (drop) bus.memoryWriteRequest = 1'b0;
      if (bus.videoReadValid) begin vcnt++; vk = k; vdata = bus.videoReadData; end
      if (bus.memoryWriteComplete) begin ccnt++; ck = k; drop = 1'b1; end
    end
    ref_mem[int'(17'h00200)] = 8'hC3;
    checks++; if (vk != 4) begin errors++; $display("FAIL prio_video_cycle got %0d exp 4", vk); end
    checks++; if (ck != 8) begin errors++; $display("FAIL prio_write_cycle got %0d exp 8", ck); end
    checks++; if (ccnt != 1 || vcnt != 1) begin errors++; $display("FAIL prio_pulse_counts got c=%0d v=%0d exp 1/1", ccnt, vcnt); end
    checks++; if (vdata !== old_v) begin errors++; $display("FAIL prio_video_data got %h exp %h", vdata, old_v); end
    checks++; if (sram_mem[17'h00200] !== 8'hC3) begin errors++; $display("FAIL prio_sram got %h exp c3", sram_mem[17'h00200]); end
    settle();
  endtask

  task automatic test_snoop();
    int oe_low = 0;
    int found = 0;
    logic drop = 1'b0;
    bus.memoryReadAddress = 17'h00010;
    settle();
    checks++; if (bus.memoryReadData !== ref_rd(17'h00010)) begin errors++; $display("FAIL snoop_pre got %h exp %h", bus.memoryReadData, ref_rd(17'h00010)); end
    bus.memoryWriteRequest = 1'b1;
    bus.memoryWriteAddress = 17'h00010;
    bus.memoryWriteData    = 8'h77;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (drop) bus.memoryWriteRequest = 1'b0;
      if (!oe_n) oe_low++;
      if (bus.memoryWriteComplete) begin
        drop = 1'b1;
        checks++;
        if (bus.memoryReadData !== 8'h77) begin errors++; $display("FAIL snoop_data got %h exp 77", bus.memoryReadData); end
      end
    end
    ref_mem[int'(17'h00010)] = 8'h77;
    checks++; if (oe_low != 0) begin errors++; $display("FAIL snoop_extra_read got %0d oe clks exp 0", oe_low); end
    bus.memoryReadAddress = 17'h00020;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (!oe_n) oe_low++;
      if (found == 0 && bus.memoryReadData === ref_rd(17'h00020)) found = k;
    end
    checks++; if (found == 0) begin errors++; $display("FAIL refresh_latency got none within 4 clks, data %h exp %h", bus.memoryReadData, ref_rd(17'h00020)); end
    checks++; if (oe_low != 2) begin errors++; $display("FAIL refresh_oe_clks got %0d exp 2", oe_low); end
    settle();
  endtask

  task automatic op_video(input logic [16:0] a);
    int vk = 0, vcnt = 0;
    logic [7:0] vdata = 8'h00;
    bus.videoReadRequest = 1'b1;
    bus.videoReadAddress = a;
    for (int k = 1; k <= 12; k++) begin
      tick();
      bus.videoReadRequest = 1'b0;
      if (bus.videoReadValid) begin vcnt++; vk = k; vdata = bus.videoReadData; end
    end
    checks++; if (vcnt != 1 || vk != 4) begin errors++; $display("FAIL rnd_vid_timing got cnt=%0d cycle=%0d exp 1/4", vcnt, vk); end
    checks++; if (vdata !== ref_rd(a)) begin errors++; $display("FAIL rnd_vid_data addr %h got %h exp %h", a, vdata, ref_rd(a)); end
  endtask

  task automatic op_write(input logic [16:0] a, input logic [7:0] d, input int mode,
                          input logic [16:0] va1, input logic [16:0] va2);
    logic [7:0] exp_v = 8'h00;
    logic [7:0] vdata = 8'h00;
    int vcnt = 0, ccnt = 0;
    logic drop = 1'b0;
    if (mode == 1) exp_v = ref_rd(va1);
    ref_mem[int'(a)] = d;
    if (mode == 2) exp_v = ref_rd(va1);
    if (mode == 3) exp_v = ref_rd(va2);
    for (int k = 0; k < 30; k++) begin
      if (k == 0) begin
        bus.memoryWriteRequest = 1'b1;
        bus.memoryWriteAddress = a;
        bus.memoryWriteData    = d;
      end
      if (drop) bus.memoryWriteRequest = 1'b0;
      bus.videoReadRequest = (mode == 1 && k == 0) || (mode >= 2 && k == 1) || (mode == 3 && k == 2);
      bus.videoReadAddress = (mode == 3 && k == 2) ? va2 : va1;
      tick();
      if (bus.videoReadValid) begin vcnt++; vdata = bus.videoReadData; end
      if (bus.memoryWriteComplete) begin ccnt++; drop = 1'b1; end
    end
    bus.memoryWriteRequest = 1'b0;
    bus.videoReadRequest   = 1'b0;
    checks++; if (ccnt != 1) begin errors++; $display("FAIL rnd_wr_complete got %0d pulses exp 1", ccnt); end
    checks++; if (vcnt != ((mode != 0) ? 1 : 0)) begin errors++; $display("FAIL rnd_wr_vid_count mode %0d got %0d", mode, vcnt); end
    if (mode != 0) begin
      checks++;
      if (vdata !== exp_v) begin errors++; $display("FAIL rnd_wr_vid_data mode %0d got %h exp %h", mode, vdata, exp_v); end
    end
    checks++; if (sram_mem[a] !== d) begin errors++; $display("FAIL rnd_wr_sram addr %h got %h exp %h", a, sram_mem[a], d); end
  endtask

  task automatic test_random();
    logic [16:0] a, va1, va2;
    int op;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 2));
      a  = 17'h0A000 + 17'($urandom_range(0, 7));
      if (op == 0) begin
        op_video(a);
      end else if (op == 1) begin
        va1 = ($urandom_range(0, 1) == 0) ? a : (17'h0A000 + 17'($urandom_range(0, 7)));
        va2 = 17'h0A000 + 17'($urandom_range(0, 7));
        op_write(a, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), va1, va2);
      end else begin
        bus.memoryReadAddress = a;
      end
      settle();
      checks++;
      if (bus.memoryReadData !== ref_rd(bus.memoryReadAddress)) begin
        errors++; $display("FAIL rnd_readback addr %h got %h exp %h", bus.memoryReadAddress, bus.memoryReadData, ref_rd(bus.memoryReadAddress));
      end
    end
    checks++;
    if (contention_cnt != 0) begin errors++; $display("FAIL bus_contention got %0d events exp 0", contention_cnt); end
  endtask

  initial begin
    bus.memoryWriteRequest = 1'b0;
    bus.memoryWriteAddress = 17'h0;
    bus.memoryWriteData    = 8'h00;
    bus.memoryReadAddress  = 17'h00033;
    bus.videoReadRequest   = 1'b0;
    bus.videoReadAddress   = 17'h0;
    test_reset();
    test_write();
    test_video();
    test_priority();
    test_snoop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
